// File: rtl/sdram_pattern_checker_if.sv
// Read-port bundle between the pattern checker and the SDRAM controller.
// The master issues one read at a time; the slave stalls with waitrequest and answers with readdatavalid.
interface sdram_pattern_checker_if #(
    parameter int ADDR_W = 25,
    parameter int W      = 16
) ();
    logic              read;
    logic [ADDR_W-1:0] readaddress;
    logic              waitrequest;
    logic [W-1:0]      readdata;
    logic              readdatavalid;

    modport master (
        output read, readaddress,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  read, readaddress,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_pattern_checker.sv
// Reads back the LFSR-generated KNN training/input records and compares every word.
// Reports pass/fail, a saturating error count, first-mismatch details and a read timeout.
module sdram_pattern_checker #(
    parameter int                M           = 6,
    parameter int                N           = 10,
    parameter int                W           = 16,
    parameter int                L           = 6,
    parameter int                NUM_I       = 10,
    parameter int                ADDR_W      = 25,
    parameter logic [ADDR_W-1:0] BASE_T_ADDR = '0,
    parameter logic [ADDR_W-1:0] BASE_I_ADDR = {1'b1, {(ADDR_W-1){1'b0}}},
    parameter int                TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    sdram_pattern_checker_if.master bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic                   o_timeout,
    output logic [15:0]            o_error_count,
    output logic [ADDR_W-1:0]      o_first_err_addr,
    output logic [W-1:0]           o_first_err_expected,
    output logic [W-1:0]           o_first_err_actual
);
    localparam int R       = M * N;
    localparam int NUM_T   = 1 << L;
    localparam int NUM_REC = NUM_T + NUM_I;
    localparam int WORD_W  = (R > 1) ? $clog2(R) : 1;
    localparam int REC_W   = $clog2(NUM_REC + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [6:0] LFSR_SEED = 7'b1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [6:0]        r_lfsr;
    logic [WORD_W-1:0] r_word;
    logic [REC_W-1:0]  r_rec;
    logic [ADDR_W-1:0] r_off;
    logic [W-1:0]      r_data;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [15:0]       r_err_cnt;
    logic [ADDR_W-1:0] r_first_addr;
    logic [W-1:0]      r_first_exp;
    logic [W-1:0]      r_first_act;

    logic [6:0]        w_rv;
    logic [W-1:0]      w_class;
    logic [W-1:0]      w_expected;
    logic [ADDR_W-1:0] w_addr;
    logic              w_is_train;
    logic              w_word_last;
    logic              w_rec_last;
    logic              w_to_hit;
    logic              w_mismatch;
    logic              w_read;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], ~(v[6] ^ v[4] ^ v[3] ^ v[2])};
    endfunction

    // r_lfsr always holds the value already stepped for the record being checked
    assign w_rv        = r_lfsr % 7'd100;
    assign w_is_train  = (r_rec < REC_W'(NUM_T));
    assign w_word_last = (r_word == WORD_W'(R - 1));
    assign w_rec_last  = (r_rec == REC_W'(NUM_REC - 1));
    assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_addr      = (w_is_train ? BASE_T_ADDR : BASE_I_ADDR) + r_off * ADDR_W'(W);
    assign w_mismatch  = (r_data != w_expected);

    always_comb begin
        w_class = W'(5);
        if (w_rv < 7'd20)      w_class = W'(1);
        else if (w_rv < 7'd40) w_class = W'(2);
        else if (w_rv < 7'd60) w_class = W'(3);
        else if (w_rv < 7'd80) w_class = W'(4);
    end

    always_comb begin
        w_expected = W'(w_rv);
        if (r_word == '0) w_expected = w_is_train ? w_class : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_read       = 1'b0;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_ISSUE;
            S_ISSUE: begin
                w_read = 1'b1;
                if (!bus.waitrequest) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.readdatavalid) w_state_next = S_CHECK;
                else if (w_to_hit)     w_state_next = S_IDLE;
            end
            S_CHECK: w_state_next = (w_word_last && w_rec_last) ? S_DONE : S_ISSUE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= LFSR_SEED;
            r_word       <= '0;
            r_rec        <= '0;
            r_off        <= '0;
            r_data       <= '0;
            r_to_cnt     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_exp  <= '0;
            r_first_act  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    // Restart from the seed so every pass matches the pattern the writer produced
                    r_lfsr       <= lfsr_step(LFSR_SEED);
                    r_word       <= '0;
                    r_rec        <= '0;
                    r_off        <= '0;
                    r_busy       <= 1'b1;
                    r_done       <= 1'b0;
                    r_pass       <= 1'b0;
                    r_timeout    <= 1'b0;
                    r_err_cnt    <= '0;
                    r_first_addr <= '0;
                    r_first_exp  <= '0;
                    r_first_act  <= '0;
                end
                S_ISSUE: if (!bus.waitrequest) r_to_cnt <= '0;
                S_WAIT: begin
                    if (bus.readdatavalid) begin
                        r_data <= bus.readdata;
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                        if (r_err_cnt == 16'd0) begin
                            r_first_addr <= w_addr;
                            r_first_exp  <= w_expected;
                            r_first_act  <= r_data;
                        end
                    end
                    if (w_word_last) begin
                        r_word <= '0;
                        r_rec  <= r_rec + REC_W'(1);
                        r_lfsr <= lfsr_step(r_lfsr);
                    end else begin
                        r_word <= r_word + WORD_W'(1);
                    end
                    // Word offset restarts when crossing from the training to the input region
                    if (w_word_last && r_rec == REC_W'(NUM_T - 1)) r_off <= '0;
                    else                                         r_off <= r_off + ADDR_W'(1);
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= (r_err_cnt == 16'd0);
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.read             = w_read;
    assign bus.readaddress      = w_addr;
    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_pass               = r_pass;
    assign o_timeout            = r_timeout;
    assign o_error_count        = r_err_cnt;
    assign o_first_err_addr     = r_first_addr;
    assign o_first_err_expected = r_first_exp;
    assign o_first_err_actual   = r_first_act;
endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Bench for sdram_pattern_checker: a memory model answers reads, a queue holds the expected address order,
// and a vector table plus hand sequences cover corruption, stalls, timeout and mid-pass reset.
module tb_sdram_pattern_checker;
    localparam int ADDR_W = 25;
    localparam int W      = 16;
    localparam int R      = 60;
    localparam int NUM_T  = 64;
    localparam int NUM_I  = 10;
    localparam int NWORDS = (NUM_T + NUM_I) * R;
    localparam logic [ADDR_W-1:0] BASE_I = 25'h1000000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, pass_o, timeout_o;
    logic [15:0]       error_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [W-1:0]      first_err_expected, first_err_actual;

    sdram_pattern_checker_if #(.ADDR_W(ADDR_W), .W(W)) bus ();

    sdram_pattern_checker dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (start),
        .bus                  (bus),
        .o_busy               (busy),
        .o_done               (done),
        .o_pass               (pass_o),
        .o_timeout            (timeout_o),
        .o_error_count        (error_count),
        .o_first_err_addr     (first_err_addr),
        .o_first_err_expected (first_err_expected),
        .o_first_err_actual   (first_err_actual)
    );

    always #5 clk = ~clk;

    logic [ADDR_W-1:0] ref_addr [NWORDS];
    logic [W-1:0]      ref_data [NWORDS];
    logic [W-1:0]      mem      [NWORDS];
    logic [ADDR_W-1:0] q_addr[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_reads = 0, addr_bad = 0, stall_bad = 0, stall_cnt = 0;
    int drop_idx = -1, drop_cyc = 0, lat = 0;
    bit stall_mode = 1'b0, rand_lat = 1'b0, pend = 1'b0;
    logic [W-1:0]      pend_data;
    logic [ADDR_W-1:0] stall_addr;

    typedef struct {
        int                cidx;
        logic [W-1:0]      cval;
        bit                stall;
        bit                rlat;
        int                exp_err;
        logic [ADDR_W-1:0] exp_faddr;
        logic [W-1:0]      exp_fexp;
        logic [W-1:0]      exp_fact;
        bit                exp_pass;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic build_model();
        logic [6:0] lf;
        int rv, idx;
        logic [W-1:0] cls;
        lf = 7'd1;
        for (int rec = 0; rec < NUM_T + NUM_I; rec++) begin
            lf = {lf[5:0], ~(lf[6] ^ lf[4] ^ lf[3] ^ lf[2])};
            rv = int'(lf) % 100;
            cls = (rv < 20) ? 16'd1 : (rv < 40) ? 16'd2 : (rv < 60) ? 16'd3 : (rv < 80) ? 16'd4 : 16'd5;
            for (int w = 0; w < R; w++) begin
                idx = rec * R + w;
                if (rec < NUM_T) begin
                    ref_addr[idx] = ADDR_W'(idx * 16);
                    ref_data[idx] = (w == 0) ? cls : W'(rv);
                end else begin
                    ref_addr[idx] = BASE_I + ADDR_W'(((rec - NUM_T) * R + w) * 16);
                    ref_data[idx] = (w == 0) ? 16'd0 : W'(rv);
                end
            end
        end
    endtask

    function automatic int addr2idx(input logic [ADDR_W-1:0] a);
        int off;
        if (a >= BASE_I) begin
            off = int'(a - BASE_I);
            if (off % 16 != 0 || off / 16 >= NUM_I * R) return -1;
            return NUM_T * R + off / 16;
        end
        off = int'(a);
        if (off % 16 != 0 || off / 16 >= NUM_T * R) return -1;
        return off / 16;
    endfunction

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory model: answers one read at a time, optionally stalling, delaying or dropping responses
    initial begin : responder
        int idx;
        logic [ADDR_W-1:0] exp_a;
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(negedge clk);
            bus.readdatavalid = 1'b0;
            bus.waitrequest   = 1'b0;
            if (rst) begin
                pend      = 1'b0;
                stall_cnt = 0;
            end else begin
                if (pend) begin
                    if (lat == 0) begin
                        bus.readdatavalid = 1'b1;
                        bus.readdata      = pend_data;
                        pend              = 1'b0;
                    end else begin
                        lat--;
                    end
                end
                if (bus.read) begin
                    if (stall_mode && (n_reads % 3 == 2) && stall_cnt < 7) begin
                        if (stall_cnt == 0) stall_addr = bus.readaddress;
                        else if (bus.readaddress !== stall_addr) stall_bad++;
                        stall_cnt++;
                        bus.waitrequest = 1'b1;
                    end else begin
                        if (stall_cnt > 0 && bus.readaddress !== stall_addr) stall_bad++;
                        stall_cnt = 0;
                        exp_a = '1;
                        if (q_addr.size() > 0) exp_a = q_addr.pop_front();
                        if (bus.readaddress !== exp_a) addr_bad++;
                        idx = addr2idx(bus.readaddress);
                        pend_data = (idx >= 0) ? mem[idx] : 16'hDEAD;
                        if (n_reads == drop_idx) begin
                            drop_cyc = cyc;
                        end else begin
                            pend = 1'b1;
                            lat  = rand_lat ? int'($urandom_range(5, 0)) : 0;
                        end
                        n_reads++;
                    end
                end
            end
        end
    end

    task automatic start_pass();
        q_addr.delete();
        for (int i = 0; i < NWORDS; i++) q_addr.push_back(ref_addr[i]);
        n_reads   = 0;
        addr_bad  = 0;
        stall_bad = 0;
        stall_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read"},        32'(bus.read), 32'd0);
        check({tag, "_readaddress"}, 32'(bus.readaddress), 32'd0);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_done"},        32'(done), 32'd0);
        check({tag, "_pass"},        32'(pass_o), 32'd0);
        check({tag, "_timeout"},     32'(timeout_o), 32'd0);
        check({tag, "_error_count"}, 32'(error_count), 32'd0);
        check({tag, "_first_addr"},  32'(first_err_addr), 32'd0);
        check({tag, "_first_exp"},   32'(first_err_expected), 32'd0);
        check({tag, "_first_act"},   32'(first_err_actual), 32'd0);
    endtask

    initial begin : main
        int k;
        rst   = 1'b1;
        start = 1'b0;
        build_model();
        // idx 60 is record 1 word 0 (address 960); idx 3840 is input record 0 word 0
        vecs[0] = '{-1,   16'd0, 1'b0, 1'b0, 0, 25'd0,   16'd0, 16'd0, 1'b1};
        vecs[1] = '{60,   16'd2, 1'b0, 1'b0, 1, 25'd960, 16'd1, 16'd2, 1'b0};
        vecs[2] = '{3840, 16'd5, 1'b0, 1'b0, 1, BASE_I,  16'd0, 16'd5, 1'b0};
        vecs[3] = '{-1,   16'd0, 1'b1, 1'b1, 0, 25'd0,   16'd0, 16'd0, 1'b1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NWORDS; i++) mem[i] = ref_data[i];
            if (vecs[v].cidx >= 0) mem[vecs[v].cidx] = vecs[v].cval;
            stall_mode = vecs[v].stall;
            rand_lat   = vecs[v].rlat;
            $display("[TB] vector %0d: corrupt_idx=%0d stall=%0d rand_lat=%0d", v, vecs[v].cidx, vecs[v].stall, vecs[v].rlat);
            start_pass();
            wait_done(60000);
            check($sformatf("v%0d_reads", v),       32'(n_reads), 32'(NWORDS));
            check($sformatf("v%0d_addr_errors", v), 32'(addr_bad), 32'd0);
            check($sformatf("v%0d_stall_moves", v), 32'(stall_bad), 32'd0);
            check($sformatf("v%0d_busy", v),        32'(busy), 32'd0);
            check($sformatf("v%0d_timeout", v),     32'(timeout_o), 32'd0);
            check($sformatf("v%0d_pass", v),        32'(pass_o), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_error_count", v), 32'(error_count), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_first_addr", v),  32'(first_err_addr), 32'(vecs[v].exp_faddr));
            check($sformatf("v%0d_first_exp", v),   32'(first_err_expected), 32'(vecs[v].exp_fexp));
            check($sformatf("v%0d_first_act", v),   32'(first_err_actual), 32'(vecs[v].exp_fact));
        end
        stall_mode = 1'b0;
        rand_lat   = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = ref_data[i];

        // Read 10 never answered: timeout after 1023 WAIT cycles (entry edge plus 1023 more edges)
        drop_idx = 10;
        start_pass();
        k = 0;
        while (!timeout_o && k < 1500) begin
            @(negedge clk);
            k++;
        end
        check("to_seen",        32'(timeout_o), 32'd1);
        check("to_edges",       32'(cyc - drop_cyc), 32'd1024);
        check("to_done",        32'(done), 32'd1);
        check("to_pass",        32'(pass_o), 32'd0);
        check("to_busy",        32'(busy), 32'd0);
        check("to_reads",       32'(n_reads), 32'd11);
        drop_idx = -1;

        // Recovery start, a start pulse while busy, then reset during record 5
        start_pass();
        check("rec_timeout_cleared", 32'(timeout_o), 32'd0);
        check("rec_done_cleared",    32'(done), 32'd0);
        check("rec_busy",            32'(busy), 32'd1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!(bus.readaddress >= 25'd4800 && bus.readaddress < BASE_I) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("rec_reached_record5", 32'(bus.readaddress >= 25'd4800 && bus.readaddress < 25'd5760), 32'd1);
        check("rec_addr_errors",     32'(addr_bad), 32'd0);
        check("rec_error_count",     32'(error_count), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_pass();
        k = 0;
        while (n_reads < 70 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("post_rst_reads",       32'(n_reads >= 70), 32'd1);
        check("post_rst_addr_errors", 32'(addr_bad), 32'd0);
        check("post_rst_error_count", 32'(error_count), 32'd0);
        check("post_rst_busy",        32'(busy), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
